nvdla_glb_csb_initiator: RTL and testbench

//  CSB master. Accepts single register-access commands from a local controller (debug/boot sequencer).

---
 rtl/nvdla_csb_pkg.sv | 34 +++
 rtl/nvdla_csb_req_pack.sv | 28 ++
 rtl/nvdla_glb_csb_initiator.sv | 185 ++++++++++++++++++
 tb/tb_nvdla_glb_csb_initiator.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvdla_csb_pkg.sv
// Shared CSB definitions: csb2xx request field layout, xx2csb response type IDs
// and the initiator FSM state encoding.
package nvdla_csb_pkg;

  localparam int ADDR_W    = 22;
  localparam int WDAT_W    = 32;
  localparam int RDAT_W    = 32;
  localparam int WRBE_W    = 4;
  localparam int LEVEL_W   = 2;
  localparam int REQ_PD_W  = 63;
  localparam int RESP_PD_W = 34;

  localparam int ADDR_LSB    = 0;
  localparam int WDAT_LSB    = 22;
  localparam int WRITE_BIT   = 54;
  localparam int NPOSTED_BIT = 55;
  localparam int SRCPRIV_BIT = 56;
  localparam int WRBE_LSB    = 57;
  localparam int LEVEL_LSB   = 61;

  localparam int RESP_ERR_BIT  = 32;
  localparam int RESP_TYPE_BIT = 33;

  localparam logic RESP_RD = 1'b0;
  localparam logic RESP_WR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_DONE      = 2'd3
  } csb_state_e;

endpackage

// File: rtl/nvdla_csb_req_pack.sv
// Combinational packer from a single register-access command to the 63-bit
// csb2xx request payload; shared by the CSB masters.
module nvdla_csb_req_pack
  import nvdla_csb_pkg::*;
(
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [WDAT_W-1:0]   i_wdat,
  input  logic                i_write,
  input  logic                i_nposted,
  input  logic                i_srcpriv,
  input  logic [WRBE_W-1:0]   i_wrbe,
  input  logic [LEVEL_W-1:0]  i_level,
  output logic [REQ_PD_W-1:0] o_pd
);

  // place each command field at its csb2xx offset
  always_comb begin
    o_pd                           = {REQ_PD_W{1'b0}};
    o_pd[ADDR_LSB +: ADDR_W]       = i_addr;
    o_pd[WDAT_LSB +: WDAT_W]       = i_wdat;
    o_pd[WRITE_BIT]                = i_write;
    o_pd[NPOSTED_BIT]              = i_nposted;
    o_pd[SRCPRIV_BIT]              = i_srcpriv;
    o_pd[WRBE_LSB +: WRBE_W]       = i_wrbe;
    o_pd[LEVEL_LSB +: LEVEL_W]     = i_level;
  end

endmodule

// File: rtl/nvdla_glb_csb_initiator.sv
// CSB master: one outstanding register access from a local controller to a CSB slave.
// Optional response timeout enabled by defining NVDLA_CSB_INITIATOR_TIMEOUT_EN.
module nvdla_glb_csb_initiator
  import nvdla_csb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13
)
(
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [ADDR_W-1:0]    i_cmd_addr,
  input  logic [WDAT_W-1:0]    i_cmd_wdat,
  input  logic                 i_cmd_write,
  input  logic                 i_cmd_nposted,
  input  logic                 i_cmd_srcpriv,
  input  logic [WRBE_W-1:0]    i_cmd_wrbe,
  input  logic [LEVEL_W-1:0]   i_cmd_level,
  output logic                 o_csb2xx_req_pvld,
  input  logic                 i_csb2xx_req_prdy,
  output logic [REQ_PD_W-1:0]  o_csb2xx_req_pd,
  input  logic                 i_xx2csb_resp_valid,
  input  logic [RESP_PD_W-1:0] i_xx2csb_resp_pd,
  output logic                 o_rsp_valid,
  output logic [RDAT_W-1:0]    o_rsp_rdat,
  output logic                 o_rsp_error,
  output logic                 o_rsp_timeout,
  output logic                 o_unsol_err,
  output logic                 o_busy
);

  csb_state_e          r_state;
  csb_state_e          w_state_nxt;
  logic [REQ_PD_W-1:0] w_pd;
  logic [REQ_PD_W-1:0] r_pd;
  logic                r_exp_type;
  logic                w_accept;
  logic                w_resp_take;
  logic                w_to_take;
  logic                w_to_hit;
  logic                r_cmd_ready;
  logic                r_req_pvld;
  logic                r_busy;
  logic                r_rsp_valid;
  logic                r_unsol_err;
  logic [RDAT_W-1:0]   r_rsp_rdat;
  logic                r_rsp_error;
  logic                r_rsp_timeout;

  nvdla_csb_req_pack u_req_pack (
    .i_addr    (i_cmd_addr),
    .i_wdat    (i_cmd_wdat),
    .i_write   (i_cmd_write),
    .i_nposted (i_cmd_nposted),
    .i_srcpriv (i_cmd_srcpriv),
    .i_wrbe    (i_cmd_wrbe),
    .i_level   (i_cmd_level),
    .o_pd      (w_pd)
  );

`ifdef NVDLA_CSB_INITIATOR_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] r_to_cnt;

  // wait counter: held at zero while requesting, counts every WAIT_RESP cycle
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_to_cnt <= {TO_W{1'b0}};
    end else if (r_state == ST_REQ) begin
      r_to_cnt <= {TO_W{1'b0}};
    end else if (r_state == ST_WAIT_RESP) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end else begin
      r_to_cnt <= r_to_cnt;
    end
  end

  assign w_to_hit = (r_to_cnt == TO_LAST);
`else
  assign w_to_hit = 1'b0;
`endif

  // next-state decode; a response arriving with the timeout still wins
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_resp_take = 1'b0;
    w_to_take   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (!i_csb2xx_req_prdy) begin
          w_state_nxt = ST_REQ;
        end else if (r_pd[WRITE_BIT] && !r_pd[NPOSTED_BIT]) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        if (i_xx2csb_resp_valid) begin
          w_resp_take = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (w_to_hit) begin
          w_to_take   = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_WAIT_RESP;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // state, request payload and handshake outputs, all decoded from next state
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_state     <= ST_IDLE;
      r_pd        <= {REQ_PD_W{1'b0}};
      r_exp_type  <= RESP_RD;
      r_cmd_ready <= 1'b1;
      r_req_pvld  <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_unsol_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_req_pvld  <= (w_state_nxt == ST_REQ);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_rsp_valid <= (w_state_nxt == ST_DONE);
      r_unsol_err <= i_xx2csb_resp_valid && (r_state != ST_WAIT_RESP);
      if (w_accept) begin
        r_pd       <= w_pd;
        r_exp_type <= i_cmd_write;
      end else begin
        r_pd       <= r_pd;
        r_exp_type <= r_exp_type;
      end
    end
  end

  // completion capture; write completions never return data
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_rsp_rdat    <= {RDAT_W{1'b0}};
      r_rsp_error   <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else if (w_resp_take) begin
      r_rsp_rdat    <= (r_exp_type == RESP_WR) ? {RDAT_W{1'b0}} : i_xx2csb_resp_pd[RDAT_W-1:0];
      r_rsp_error   <= i_xx2csb_resp_pd[RESP_ERR_BIT] |
                       (i_xx2csb_resp_pd[RESP_TYPE_BIT] != r_exp_type);
      r_rsp_timeout <= 1'b0;
    end else if (w_to_take) begin
      r_rsp_rdat    <= {RDAT_W{1'b0}};
      r_rsp_error   <= 1'b1;
      r_rsp_timeout <= 1'b1;
    end else begin
      r_rsp_rdat    <= r_rsp_rdat;
      r_rsp_error   <= r_rsp_error;
      r_rsp_timeout <= r_rsp_timeout;
    end
  end

  assign o_cmd_ready       = r_cmd_ready;
  assign o_csb2xx_req_pvld = r_req_pvld;
  assign o_csb2xx_req_pd   = r_pd;
  assign o_rsp_valid       = r_rsp_valid;
  assign o_rsp_rdat        = r_rsp_rdat;
  assign o_rsp_error       = r_rsp_error;
  assign o_rsp_timeout     = r_rsp_timeout;
  assign o_unsol_err       = r_unsol_err;
  assign o_busy            = r_busy;

endmodule

// File: tb/tb_nvdla_glb_csb_initiator.sv
// Self-checking bench for nvdla_glb_csb_initiator: directed vector table, corner
// sequences and randomized transactions against a spec-level reference model.
`timescale 1ns/1ps
module tb_nvdla_glb_csb_initiator;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_nposted, cmd_srcpriv;
  logic [21:0] cmd_addr;
  logic [31:0] cmd_wdat;
  logic [3:0]  cmd_wrbe;
  logic [1:0]  cmd_level;
  logic        req_pvld, req_prdy;
  logic [62:0] req_pd;
  logic        resp_valid;
  logic [33:0] resp_pd;
  logic        rsp_valid, rsp_error, rsp_timeout, unsol_err, busy;
  logic [31:0] rsp_rdat;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  nvdla_glb_csb_initiator #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .nvdla_core_clk      (clk),
    .nvdla_core_rstn     (rstn),
    .i_cmd_valid         (cmd_valid),
    .o_cmd_ready         (cmd_ready),
    .i_cmd_addr          (cmd_addr),
    .i_cmd_wdat          (cmd_wdat),
    .i_cmd_write         (cmd_write),
    .i_cmd_nposted       (cmd_nposted),
    .i_cmd_srcpriv       (cmd_srcpriv),
    .i_cmd_wrbe          (cmd_wrbe),
    .i_cmd_level         (cmd_level),
    .o_csb2xx_req_pvld   (req_pvld),
    .i_csb2xx_req_prdy   (req_prdy),
    .o_csb2xx_req_pd     (req_pd),
    .i_xx2csb_resp_valid (resp_valid),
    .i_xx2csb_resp_pd    (resp_pd),
    .o_rsp_valid         (rsp_valid),
    .o_rsp_rdat          (rsp_rdat),
    .o_rsp_error         (rsp_error),
    .o_rsp_timeout       (rsp_timeout),
    .o_unsol_err         (unsol_err),
    .o_busy              (busy)
  );

  typedef struct {
    logic [21:0] addr;
    logic [31:0] wdat;
    logic        write, nposted, srcpriv;
    logic [3:0]  wrbe;
    logic [1:0]  level;
    int          prdy_dly, resp_dly;
    logic        rtype, rerr;
    logic [31:0] rrdat;
    logic        exp_rsp;
    logic [31:0] exp_rdat;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [21:0] a, input logic [31:0] wd, input logic w, np, sp,
                              input logic [3:0] be, input logic [1:0] lv, input int pdl, rdl,
                              input logic rt, re, input logic [31:0] rr,
                              input logic xr, input logic [31:0] xd, input logic xe);
    vec_t v;
    v.addr = a; v.wdat = wd; v.write = w; v.nposted = np; v.srcpriv = sp; v.wrbe = be;
    v.level = lv; v.prdy_dly = pdl; v.resp_dly = rdl; v.rtype = rt; v.rerr = re; v.rrdat = rr;
    v.exp_rsp = xr; v.exp_rdat = xd; v.exp_err = xe;
    return v;
  endfunction

  // Reference model: completion only for reads and non-posted writes; writes return no data;
  // error is the slave error or a response of the wrong kind.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    r.exp_rsp  = !(v.write && !v.nposted);
    r.exp_rdat = v.write ? 32'h0 : v.rrdat;
    r.exp_err  = v.rerr || (v.rtype != v.write);
    return r;
  endfunction

  task automatic run_txn(input vec_t v);
    logic [62:0] exp_pd;
    exp_pd = {v.level, v.wrbe, v.srcpriv, v.nposted, v.write, v.wdat, v.addr};
    check("idle_ready", cmd_ready, 1'b1);
    check("idle_pvld", req_pvld, 1'b0);
    cmd_valid = 1'b1; cmd_addr = v.addr; cmd_wdat = v.wdat; cmd_write = v.write;
    cmd_nposted = v.nposted; cmd_srcpriv = v.srcpriv; cmd_wrbe = v.wrbe; cmd_level = v.level;
    step();
    cmd_valid = 1'b0; cmd_addr = 22'($urandom); cmd_wdat = $urandom; cmd_level = 2'($urandom);
    for (int i = 0; i <= v.prdy_dly; i++) begin
      check("req_pvld", req_pvld, 1'b1);
      check("req_pd", req_pd, exp_pd);
      check("req_ready_low", cmd_ready, 1'b0);
      if (i == v.prdy_dly) req_prdy = 1'b1;
      step();
    end
    req_prdy = 1'b0;
    if (!v.exp_rsp) begin
      check("posted_ready", cmd_ready, 1'b1);
      check("posted_pvld", req_pvld, 1'b0);
      check("posted_busy", busy, 1'b0);
      step();
      check("posted_no_rsp", rsp_valid, 1'b0);
    end else begin
      for (int i = 0; i < v.resp_dly; i++) begin
        check("wait_no_rsp", rsp_valid, 1'b0);
        check("wait_busy", busy, 1'b1);
        step();
      end
      resp_valid = 1'b1;
      resp_pd    = {v.rtype, v.rerr, v.rrdat};
      step();
      resp_valid = 1'b0;
      resp_pd    = 34'($urandom);
      check("rsp_valid", rsp_valid, 1'b1);
      check("rsp_rdat", rsp_rdat, v.exp_rdat);
      check("rsp_error", rsp_error, v.exp_err);
      check("rsp_timeout", rsp_timeout, 1'b0);
      check("rsp_unsol", unsol_err, 1'b0);
      step();
      check("rsp_pulse", rsp_valid, 1'b0);
      check("next_ready", cmd_ready, 1'b1);
    end
  endtask

  task automatic issue_read(input logic [21:0] addr, input logic resp_in_hs);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_write = 1'b0; cmd_nposted = 1'b0;
    step();
    cmd_valid  = 1'b0;
    req_prdy   = 1'b1;
    resp_valid = resp_in_hs;
    resp_pd    = {1'b0, 1'b0, 32'h1111_1111};
    step();
    req_prdy   = 1'b0;
    resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs [6];
    vec_t v;
    int   bad;

    vecs[0] = mk(22'h00A10, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 0, 0,
                 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b0);
    vecs[1] = mk(22'h00040, 32'h12345678, 1'b1, 1'b0, 1'b1, 4'hF, 2'd1, 3, 0,
                 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    vecs[2] = mk(22'h1F000, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0, 4'h3, 2'd2, 1, 2,
                 1'b0, 1'b0, 32'hCAFE0000, 1'b1, 32'h0, 1'b1);
    vecs[3] = mk(22'h00004, 32'h0, 1'b0, 1'b0, 1'b1, 4'h0, 2'd0, 0, 1,
                 1'b0, 1'b1, 32'h000055AA, 1'b1, 32'h000055AA, 1'b1);
    vecs[4] = mk(22'h20000, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 2'd3, 2, 0,
                 1'b1, 1'b0, 32'h0BADF00D, 1'b1, 32'h0BADF00D, 1'b1);
    vecs[5] = mk(22'h3FFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 4'h8, 2'd3, 0, 3,
                 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0);

    rstn = 1'b0; cmd_valid = 1'b0; cmd_addr = 22'h0; cmd_wdat = 32'h0; cmd_write = 1'b0;
    cmd_nposted = 1'b0; cmd_srcpriv = 1'b0; cmd_wrbe = 4'h0; cmd_level = 2'd0;
    req_prdy = 1'b0; resp_valid = 1'b0; resp_pd = 34'h0;
    repeat (3) step();
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_pvld", req_pvld, 1'b0);
    check("rst_pd", req_pd, 63'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdat", rsp_rdat, 32'h0);
    check("rst_rsp_error", rsp_error, 1'b0);
    check("rst_rsp_timeout", rsp_timeout, 1'b0);
    check("rst_unsol", unsol_err, 1'b0);
    @(negedge clk) rstn = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // stray response while idle
    resp_valid = 1'b1; resp_pd = {1'b0, 1'b0, 32'h77777777};
    step();
    resp_valid = 1'b0;
    check("idle_unsol", unsol_err, 1'b1);
    check("idle_unsol_no_rsp", rsp_valid, 1'b0);
    check("idle_unsol_busy", busy, 1'b0);
    check("idle_unsol_ready", cmd_ready, 1'b1);
    step();
    check("idle_unsol_pulse", unsol_err, 1'b0);

    // response on the handshake cycle and again in DONE
    issue_read(22'h00123, 1'b1);
    check("hs_unsol", unsol_err, 1'b1);
    check("hs_busy", busy, 1'b1);
    check("hs_no_rsp", rsp_valid, 1'b0);
    step();
    check("hs_unsol_pulse", unsol_err, 1'b0);
    check("hs_ignored", rsp_valid, 1'b0);
    resp_valid = 1'b1; resp_pd = {1'b0, 1'b0, 32'h2468ACE0};
    step();
    resp_pd = {1'b0, 1'b0, 32'h99999999};
    check("hs_rsp_valid", rsp_valid, 1'b1);
    check("hs_rsp_rdat", rsp_rdat, 32'h2468ACE0);
    step();
    resp_valid = 1'b0;
    check("done_unsol", unsol_err, 1'b1);
    check("done_no_rsp", rsp_valid, 1'b0);
    check("done_rdat_kept", rsp_rdat, 32'h2468ACE0);
    step();

`ifdef NVDLA_CSB_INITIATOR_TIMEOUT_EN
    issue_read(22'h00321, 1'b0);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (rsp_valid !== 1'b0) bad++;
      step();
    end
    check("to_early_rsp", bad, 0);
    check("to_rsp_valid", rsp_valid, 1'b1);
    check("to_rsp_error", rsp_error, 1'b1);
    check("to_rsp_timeout", rsp_timeout, 1'b1);
    check("to_rsp_rdat", rsp_rdat, 32'h0);
    resp_valid = 1'b1; resp_pd = {1'b0, 1'b0, 32'h13579BDF};
    step();
    resp_valid = 1'b0;
    check("to_late_unsol", unsol_err, 1'b1);
    check("to_late_no_rsp", rsp_valid, 1'b0);
    step();
`else
    issue_read(22'h00321, 1'b0);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (rsp_valid !== 1'b0 || busy !== 1'b1) bad++;
      step();
    end
    check("no_to_wait", bad, 0);
    resp_valid = 1'b1; resp_pd = {1'b0, 1'b0, 32'h600DF00D};
    step();
    resp_valid = 1'b0;
    check("no_to_rsp_valid", rsp_valid, 1'b1);
    check("no_to_rdat", rsp_rdat, 32'h600DF00D);
    check("no_to_timeout", rsp_timeout, 1'b0);
    step();
`endif

    // reset while the request is pending
    cmd_valid = 1'b1; cmd_addr = 22'h00555; cmd_write = 1'b0;
    step();
    cmd_valid = 1'b0;
    check("pre_rst_pvld", req_pvld, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check("rst_req_pvld", req_pvld, 1'b0);
    check("rst_req_busy", busy, 1'b0);
    check("rst_req_ready", cmd_ready, 1'b1);
    @(negedge clk) rstn = 1'b1;
    step();
    check("rst_req_no_rsp", rsp_valid, 1'b0);

    // reset while waiting for the response
    issue_read(22'h00777, 1'b0);
    check("pre_rst_busy", busy, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check("rst_wait_busy", busy, 1'b0);
    check("rst_wait_pvld", req_pvld, 1'b0);
    @(negedge clk) rstn = 1'b1;
    step();
    check("rst_wait_no_rsp", rsp_valid, 1'b0);
    run_txn(vecs[0]);

    for (int n = 0; n < 40; n++) begin
      v.addr = 22'($urandom); v.wdat = $urandom; v.write = 1'($urandom);
      v.nposted = 1'($urandom); v.srcpriv = 1'($urandom); v.wrbe = 4'($urandom);
      v.level = 2'($urandom); v.prdy_dly = $urandom_range(0, 3); v.resp_dly = $urandom_range(0, 3);
      v.rtype = ($urandom_range(0, 3) == 0) ? ~v.write : v.write;
      v.rerr = ($urandom_range(0, 7) == 0); v.rrdat = $urandom;
      v = model(v);
      run_txn(v);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
